// File: rtl/result_streamer_pkg.sv
// Shared definitions for the result drain path: FSM state encoding and the
// default result-memory geometry (memory B: 4 words x 8 bits), which the
// processing block uses for its own memory B sizing.
package result_stream_pkg;

    localparam int DEF_NDB    = 8;   // result word width
    localparam int DEF_NWORDS = 4;   // words drained per run
    localparam int DEF_AW     = 2;   // read address width, 2**AW >= NWORDS

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LATCH,
        SEND,
        DONE
    } state_t;

endpackage

// File: rtl/result_streamer_if.sv
// Valid/ready output stream carrying drained result words.
// master: producer (result_streamer); slave: consumer.
interface result_streamer_if #(
    parameter int NDB = result_stream_pkg::DEF_NDB
) ();

    logic [NDB-1:0] out_data;
    logic           out_valid;
    logic           out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/result_streamer_stream_out_reg.sv
// Output holding register for the result stream. A loaded word stays on
// o_data with o_valid high until it is accepted or the run is cleared;
// o_data keeps its last value afterwards.
module stream_out_reg #(
    parameter int NDB = result_stream_pkg::DEF_NDB
) (
    input  logic           clock,
    input  logic           Reset,
    input  logic           i_load,
    input  logic [NDB-1:0] i_load_data,
    input  logic           i_accept,
    input  logic           i_clear,
    output logic [NDB-1:0] o_data,
    output logic           o_valid
);

    logic [NDB-1:0] r_data;
    logic           r_valid;

    // Capture on load; retire on accept or clear (clear wins over load)
    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            // NOTE: the data register is reset as well so the block's
            // post-reset outputs are fully defined, not just o_valid.
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_clear || i_accept) begin
            // NOTE: non-blocking assignments keep every register updating
            // from pre-edge values, independent of statement order.
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_load_data;
            r_valid <= 1'b1;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule

// File: rtl/result_streamer.sv
// result_streamer: drains the processing block's result RAM (synchronous
// read, one cycle latency) in address order onto a valid/ready stream, then
// pulses o_done for one cycle.
// Optional feature macro: CHECKSUM_EN adds o_checksum, the modulo-2^NDB sum
// of the words accepted in the current run.
module result_streamer
    import result_stream_pkg::*;
#(
    parameter int NDB    = DEF_NDB,
    parameter int NWORDS = DEF_NWORDS,
    parameter int AW     = DEF_AW
) (
    input  logic                  clock,
    input  logic                  Reset,
    input  logic                  i_start,
    input  logic                  i_abort,
    output logic [AW-1:0]         o_rd_addr,
    input  logic [NDB-1:0]        i_rd_data,
    result_streamer_if.master     m_out,
    output logic                  o_busy,
`ifdef CHECKSUM_EN
    output logic [NDB-1:0]        o_checksum,
`endif
    output logic                  o_done
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NWORDS - 1);

    state_t        r_state;
    logic [AW-1:0] r_idx;
    logic [AW-1:0] r_rd_addr;
    logic          r_busy;
    logic          r_done;

    logic          w_start_ok;
    logic          w_handshake;
    logic          w_load;

    // Abort overrides every other event, including a coincident Start
    assign w_start_ok  = (r_state == IDLE) && i_start && !i_abort;
    assign w_handshake = (r_state == SEND) && m_out.out_ready && !i_abort;
    assign w_load      = (r_state == LATCH) && !i_abort;

    // Drain sequencer: address generation, word index, busy and done flags.
    // rd_addr is updated on entry to READ so the RAM sees it for the whole
    // READ cycle and rd_data is ready during LATCH.
    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_rd_addr <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_abort) begin
                r_state <= IDLE;
                r_idx   <= '0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (i_start) begin
                            r_state   <= READ;
                            r_idx     <= '0;
                            r_rd_addr <= '0;
                            r_busy    <= 1'b1;
                        end
                    end
                    READ:  r_state <= LATCH;
                    LATCH: r_state <= SEND;
                    SEND: begin
                        if (m_out.out_ready) begin
                            if (r_idx == LAST_IDX) begin
                                r_state <= DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_idx     <= r_idx + 1'b1;
                                r_rd_addr <= r_idx + 1'b1;
                                r_state   <= READ;
                            end
                        end
                    end
                    DONE: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    stream_out_reg #(.NDB(NDB)) u_out_reg (
        .clock       (clock),
        .Reset       (Reset),
        .i_load      (w_load),
        .i_load_data (i_rd_data),
        .i_accept    (w_handshake),
        .i_clear     (i_abort),
        .o_data      (m_out.out_data),
        .o_valid     (m_out.out_valid)
    );

`ifdef CHECKSUM_EN
    logic [NDB-1:0] r_checksum;

    // Running sum of accepted words; cleared when a run starts, kept on Abort
    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            r_checksum <= '0;
        end else if (w_start_ok) begin
            r_checksum <= '0;
        end else if (w_handshake) begin
            r_checksum <= r_checksum + m_out.out_data;
        end
    end

    assign o_checksum = r_checksum;
`endif

    assign o_rd_addr = r_rd_addr;
    assign o_busy    = r_busy;
    assign o_done    = r_done;

endmodule

// File: tb/tb_result_streamer.sv
// Testbench for result_streamer: directed scenarios plus randomized runs.
// Stimulus pushes the expected word sequence of each run into a queue; a
// negedge monitor pops and compares on every output handshake and checks
// done/busy/checksum/latency against the model.
`timescale 1ns/1ps
module tb_result_streamer;
    import result_stream_pkg::*;

    localparam int NDB = DEF_NDB;
    localparam int NW  = DEF_NWORDS;
    localparam int AW  = DEF_AW;

    logic           clock   = 1'b0;
    logic           Reset   = 1'b1;
    logic           i_start = 1'b0;
    logic           i_abort = 1'b0;
    logic [AW-1:0]  rd_addr;
    logic [NDB-1:0] rd_data;
    logic           busy;
    logic           done;
`ifdef CHECKSUM_EN
    logic [NDB-1:0] checksum;
`endif

    result_streamer_if #(.NDB(NDB)) s_if ();

    result_streamer #(.NDB(NDB), .NWORDS(NW), .AW(AW)) dut (
        .clock      (clock),
        .Reset      (Reset),
        .i_start    (i_start),
        .i_abort    (i_abort),
        .o_rd_addr  (rd_addr),
        .i_rd_data  (rd_data),
        .m_out      (s_if.master),
        .o_busy     (busy),
`ifdef CHECKSUM_EN
        .o_checksum (checksum),
`endif
        .o_done     (done)
    );

    always #5 clock = ~clock;

    // Result RAM model: synchronous read, data one cycle after the address
    logic [NDB-1:0] ram [NW];
    always @(posedge clock) rd_data <= ram[rd_addr];

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Scoreboard state
    int             n_cmp = 0;
    int             n_bad = 0;
    logic [NDB-1:0] exp_q [$];
    int             exp_sum = 0;
    int             exp_lat = 0;     // 0: no timing check for this run
    int             start_edge = 0;
    bit             first_pending = 0;
    bit             busy_fall_pending = 0;
    int             done_cnt = 0;
    int             word_cnt = 0;
    logic           prev_valid = 1'b0;
    logic           prev_ready = 1'b0;
    logic [NDB-1:0] prev_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge
    always @(negedge clock) begin
        if (!Reset) begin
            if (i_start && !i_abort && !busy) begin
                start_edge    = cyc + 1;
                first_pending = 1'b1;
            end
            if (s_if.out_valid && !prev_valid && first_pending) begin
                first_pending = 1'b0;
                if (exp_lat > 0) check("start_latency", cyc - start_edge, 2);
            end
            if (prev_valid && !prev_ready && s_if.out_valid)
                check("hold_data", s_if.out_data, prev_data);
            if (s_if.out_valid && s_if.out_ready) begin
                word_cnt++;
                if (exp_q.size() == 0) check("extra_word", 1, 0);
                else check("word", s_if.out_data, exp_q.pop_front());
            end
            if (busy_fall_pending) begin
                check("busy_after_done", busy, 0);
                busy_fall_pending = 1'b0;
            end
            if (done) begin
                done_cnt++;
                check("done_all_words", exp_q.size(), 0);
                check("busy_at_done", busy, 1);
                if (exp_lat > 0) check("done_latency", cyc - start_edge, exp_lat);
`ifdef CHECKSUM_EN
                check("checksum", checksum, exp_sum);
`endif
                busy_fall_pending = 1'b1;
            end
            prev_valid = s_if.out_valid;
            prev_ready = s_if.out_ready;
            prev_data  = s_if.out_data;
        end else begin
            prev_valid        = 1'b0;
            first_pending     = 1'b0;
            busy_fall_pending = 1'b0;
        end
    end

    // Issue a Start pulse and queue the run's expected words; returns just
    // after the Start edge (E0 + 1ns).
    task automatic drive_start(input int lat);
        int s;
        s = 0;
        @(posedge clock); #1;
        exp_lat = lat;
        for (int i = 0; i < NW; i++) begin
            exp_q.push_back(ram[i]);
            s += int'(ram[i]);
        end
        exp_sum = s % (1 << NDB);
        i_start = 1'b1;
        @(posedge clock); #1;
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int target, input bit rnd);
        int k;
        k = 0;
        while (done_cnt < target && k < 300) begin
            @(posedge clock); #1;
            if (rnd) s_if.out_ready = 1'($urandom_range(0, 1));
            k++;
        end
        if (done_cnt < target) check("done_timeout", done_cnt, target);
        s_if.out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
    endtask

    task automatic load_fixed();
        ram[0] = 8'h05; ram[1] = 8'hFE; ram[2] = 8'h10; ram[3] = 8'h80;
    endtask

    initial begin
        int base;
        s_if.out_ready = 1'b1;
        load_fixed();
        repeat (3) @(posedge clock);
        #2 Reset = 1'b0;

        // Reset state
        @(negedge clock);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_out_data", s_if.out_data, 0);
        check("rst_out_valid", s_if.out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
`ifdef CHECKSUM_EN
        check("rst_checksum", checksum, 0);
`endif

        // Full run, ready high; a second Start mid-run must be ignored
        base = word_cnt;
        drive_start(12);
        repeat (4) @(posedge clock);
        #1 i_start = 1'b1;
        @(posedge clock); #1 i_start = 1'b0;
        wait_done(1, 1'b0);
        check("run1_words", word_cnt - base, 4);
        check("run1_dones", done_cnt, 1);

        // Consumer stalls 5 cycles on word 2: run stretches by 5
        base = word_cnt;
        drive_start(17);
        repeat (3) @(posedge clock);
        #1 s_if.out_ready = 1'b0;
        repeat (7) @(posedge clock);
        #1 s_if.out_ready = 1'b1;
        wait_done(2, 1'b0);
        check("stall_words", word_cnt - base, 4);

        // Abort while word 2 (FE) waits in SEND
        drive_start(0);
        repeat (3) @(posedge clock);
        #1 s_if.out_ready = 1'b0;
        repeat (4) @(posedge clock);
        #1 i_abort = 1'b1;
        @(posedge clock); #1 i_abort = 1'b0;
        exp_q.delete();
        @(negedge clock);
        check("abort_valid", s_if.out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_data_kept", s_if.out_data, 8'hFE);
`ifdef CHECKSUM_EN
        check("abort_partial_sum", checksum, 8'h05);
`endif
        s_if.out_ready = 1'b1;
        repeat (4) @(posedge clock);
        #1 check("abort_no_done", done_cnt, 2);
        drive_start(12);
        wait_done(3, 1'b0);

        // Asynchronous reset in LATCH of word 2
        drive_start(12);
        repeat (4) @(posedge clock);
        #2 Reset = 1'b1;
        #1;
        check("arst_out_valid", s_if.out_valid, 0);
        check("arst_out_data", s_if.out_data, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_rd_addr", rd_addr, 0);
`ifdef CHECKSUM_EN
        check("arst_checksum", checksum, 0);
`endif
        exp_q.delete();
        #3 Reset = 1'b0;
        repeat (2) @(posedge clock);
        #1 check("arst_no_done", done_cnt, 3);
        drive_start(12);
        wait_done(4, 1'b0);

        // Start and Abort together in IDLE: Abort wins
        @(posedge clock); #1;
        i_start = 1'b1; i_abort = 1'b1;
        @(posedge clock); #1;
        i_start = 1'b0; i_abort = 1'b0;
        @(negedge clock);
        check("sa_busy", busy, 0);
        check("sa_valid", s_if.out_valid, 0);
        repeat (3) @(posedge clock);
        #1 check("sa_busy_later", busy, 0);
        check("sa_no_done", done_cnt, 4);

        // Randomized contents and consumer backpressure
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NW; i++) ram[i] = NDB'($urandom);
            base = word_cnt;
            drive_start(0);
            wait_done(5 + r, 1'b1);
            check("rand_words", word_cnt - base, 4);
        end

        check("total_dones", done_cnt, 10);
        check("queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global time limit so the bench always terminates
    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "time limit exceeded");
    end

endmodule
